// File: rtl/pipeline_hazard_ctrl.sv
// In-order pipeline hazard control: a 3-stage destination scoreboard with no bypass,
// branch flush sequencing and a saturating stall-cycle counter.
module pipeline_hazard_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        dec_valid,
   input  logic [4:0]  dec_src1,
   input  logic [4:0]  dec_src2,
   input  logic        dec_src1_en,
   input  logic        dec_src2_en,
   input  logic [4:0]  dec_dst,
   input  logic        dec_dst_en,
   input  logic        br_taken,
   input  logic        mem_busy,
   input  logic        stall_clr,
   output logic        d_pass,
   output logic        d_pcincr,
   output logic        flush,
   output logic [1:0]  state,
   output logic [15:0] stall_cnt
);

   localparam int unsigned REG_W = 5;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned DEPTH = 3;

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      FLUSH = 2'b01
   } state_e;

   typedef struct packed {
      logic             vld;
      logic [REG_W-1:0] dst;
   } sb_entry_t;

   state_e                      state_q, state_d;
   sb_entry_t [DEPTH-1:0]       sb_q, sb_d;
   logic      [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

   logic in_run;
   logic in_flush;
   logic hazard;
   logic issue;

   function automatic logic src_hit(input sb_entry_t e, input logic en, input logic [REG_W-1:0] src);
      return e.vld & en & (e.dst == src);
   endfunction

   // Hazard detection, issue decision and next-state logic; outputs forced low in reset.
   always_comb begin
      in_run   = (state_q == RUN);
      in_flush = (state_q == FLUSH);

      hazard = src_hit(sb_q[0], dec_src1_en, dec_src1) | src_hit(sb_q[1], dec_src1_en, dec_src1) |
               src_hit(sb_q[2], dec_src1_en, dec_src1) | src_hit(sb_q[0], dec_src2_en, dec_src2) |
               src_hit(sb_q[1], dec_src2_en, dec_src2) | src_hit(sb_q[2], dec_src2_en, dec_src2);

      issue = dec_valid & ~hazard & ~mem_busy & in_run & ~br_taken;

      d_pass   = rst & issue;
      d_pcincr = rst & (br_taken | in_flush | (~mem_busy & ~(dec_valid & hazard)));
      flush    = rst & (br_taken | in_flush);

      // A taken branch always (re)enters FLUSH; everything else, including stray encodings, returns to RUN.
      state_d = br_taken ? FLUSH : RUN;

      // The scoreboard keeps shifting through branches: older instructions still retire.
      sb_d[0].vld = issue & dec_dst_en;
      sb_d[0].dst = issue ? dec_dst : '0;
      sb_d[1]     = sb_q[0];
      sb_d[2]     = sb_q[1];

      stall_cnt_d = stall_cnt_q;
      if (stall_clr) begin
         stall_cnt_d = '0;
      end else if (in_run && !br_taken && dec_valid && !issue && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RUN;
         sb_q        <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         sb_q        <= sb_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign state     = state_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-age
// reference model of register writes, branch flush and stall accounting.
module tb_pipeline_hazard_ctrl;

   logic        clk;
   logic        rst;
   logic        dec_valid;
   logic [4:0]  dec_src1, dec_src2, dec_dst;
   logic        dec_src1_en, dec_src2_en, dec_dst_en;
   logic        br_taken, mem_busy, stall_clr;
   logic        d_pass, d_pcincr, flush;
   logic [1:0]  state;
   logic [15:0] stall_cnt;

   pipeline_hazard_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .dec_valid  (dec_valid),
      .dec_src1   (dec_src1),
      .dec_src2   (dec_src2),
      .dec_src1_en(dec_src1_en),
      .dec_src2_en(dec_src2_en),
      .dec_dst    (dec_dst),
      .dec_dst_en (dec_dst_en),
      .br_taken   (br_taken),
      .mem_busy   (mem_busy),
      .stall_clr  (stall_clr),
      .d_pass     (d_pass),
      .d_pcincr   (d_pcincr),
      .flush      (flush),
      .state      (state),
      .stall_cnt  (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: cycle number of the latest issued write per register, branch-previous flag, stall total.
   int cyc;
   int last_wr [32];
   bit m_flush;
   int m_stall;

   logic o_pass, o_pc, o_fl;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) last_wr[r] = -100;
      m_flush = 1'b0;
      m_stall = 0;
   endtask

   // A register written in the last three cycles is not yet readable.
   function automatic bit busy_reg(input logic [4:0] r);
      return (cyc - last_wr[r]) <= 3;
   endfunction

   task automatic drive(input bit v, input int s1, input bit s1e, input int s2, input bit s2e,
                        input int d, input bit de, input bit br, input bit mb, input bit clr);
      dec_valid   = v;
      dec_src1    = 5'(s1);
      dec_src1_en = s1e;
      dec_src2    = 5'(s2);
      dec_src2_en = s2e;
      dec_dst     = 5'(d);
      dec_dst_en  = de;
      br_taken    = br;
      mem_busy    = mb;
      stall_clr   = clr;
   endtask

   // One clock: inputs already driven after the falling edge.
   task automatic step();
      bit haz, ep, epc, efl;
      #1;
      haz = (dec_src1_en && busy_reg(dec_src1)) || (dec_src2_en && busy_reg(dec_src2));
      ep  = dec_valid && !haz && !mem_busy && !m_flush && !br_taken;
      epc = br_taken || m_flush || (!mem_busy && !(dec_valid && haz));
      efl = br_taken || m_flush;
      o_pass = d_pass;
      o_pc   = d_pcincr;
      o_fl   = flush;
      chk("d_pass",   32'(d_pass),   32'(ep));
      chk("d_pcincr", 32'(d_pcincr), 32'(epc));
      chk("flush",    32'(flush),    32'(efl));
      @(posedge clk);
      if (ep && dec_dst_en) last_wr[dec_dst] = cyc;
      if (stall_clr) m_stall = 0;
      else if (!m_flush && !br_taken && dec_valid && !ep && m_stall < 65535) m_stall++;
      m_flush = br_taken;
      cyc++;
      #1;
      chk("state",     32'(state),     m_flush ? 32'd1 : 32'd0);
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      @(negedge clk);
   endtask

   // Asynchronous reset asserted between edges; outputs must drop at once.
   task automatic async_reset();
      #2;
      rst = 1'b0;
      #1;
      chk("rst_d_pass",    32'(d_pass),    32'd0);
      chk("rst_d_pcincr",  32'(d_pcincr),  32'd0);
      chk("rst_flush",     32'(flush),     32'd0);
      chk("rst_state",     32'(state),     32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      cyc = 0;
      model_reset();
      rst = 1'b0;
      drive(1, 0, 1, 0, 1, 0, 1, 1, 0, 0);
      repeat (3) @(negedge clk);
      chk("reset_forced_d_pass", 32'(d_pass),   32'd0);
      chk("reset_forced_pcincr", 32'(d_pcincr), 32'd0);
      chk("reset_forced_flush",  32'(flush),    32'd0);
      chk("reset_state",         32'(state),    32'd0);
      chk("reset_stall_cnt",     32'(stall_cnt), 32'd0);
      rst = 1'b1;

      // RAW dependency: r3 writer then reader stalls three cycles.
      drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      step();
      chk("raw_writer_pass", 32'(o_pass), 32'd1);
      drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("raw_stall_pass", 32'(o_pass), 32'd0);
         chk("raw_stall_pc",   32'(o_pc),   32'd0);
      end
      chk("raw_stall_cnt", 32'(stall_cnt), 32'd3);
      step();
      chk("raw_release_pass", 32'(o_pass), 32'd1);

      // Back-to-back independent instructions.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step();
      drive(1, 1, 1, 2, 1, 4, 1, 0, 0, 0);
      step();
      chk("indep1_pass", 32'(o_pass), 32'd1);
      chk("indep1_pc",   32'(o_pc),   32'd1);
      drive(1, 5, 1, 6, 1, 7, 1, 0, 0, 0);
      step();
      chk("indep2_pass", 32'(o_pass), 32'd1);
      chk("indep2_pc",   32'(o_pc),   32'd1);
      chk("indep_stall_cnt", 32'(stall_cnt), 32'd0);

      // Taken branch: two flush cycles.
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      step();
      chk("br0_flush", 32'(o_fl), 32'd1);
      chk("br0_pass",  32'(o_pass), 32'd0);
      chk("br0_pc",    32'(o_pc), 32'd1);
      chk("br0_state", 32'(state), 32'd1);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("br1_flush", 32'(o_fl), 32'd1);
      chk("br1_pass",  32'(o_pass), 32'd0);
      chk("br1_pc",    32'(o_pc), 32'd1);
      chk("br1_state", 32'(state), 32'd0);
      step();
      chk("br_after_pass", 32'(o_pass), 32'd1);

      // Memory busy for four cycles.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step();
      drive(1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("mb_pass", 32'(o_pass), 32'd0);
         chk("mb_pc",   32'(o_pc),   32'd0);
      end
      chk("mb_stall_cnt", 32'(stall_cnt), 32'd4);
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("mb_resume_pass", 32'(o_pass), 32'd1);

      // Drive the stall counter into saturation, then clear it.
      drive(1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
      for (int k = 0; k < 65540; k++) step();
      chk("sat_stall_cnt", 32'(stall_cnt), 32'h0000_ffff);
      drive(1, 1, 1, 0, 0, 0, 0, 0, 1, 1);
      step();
      chk("clr_stall_cnt", 32'(stall_cnt), 32'd0);

      // Reset in the middle of FLUSH with writers in flight.
      drive(1, 0, 0, 0, 0, 10, 1, 0, 0, 0); step();
      drive(1, 0, 0, 0, 0, 11, 1, 0, 0, 0); step();
      drive(1, 0, 0, 0, 0, 12, 1, 0, 0, 0); step();
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();
      chk("pre_rst_state", 32'(state), 32'd1);
      drive(1, 12, 1, 11, 1, 0, 0, 1, 0, 0);
      async_reset();
      drive(1, 12, 1, 11, 1, 0, 0, 0, 0, 0);
      step();
      chk("post_rst_pass", 32'(o_pass), 32'd1);
      chk("post_rst_pc",   32'(o_pc),   32'd1);

      // Random traffic with occasional asynchronous resets.
      for (int k = 0; k < 3000; k++) begin
         drive($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
               $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
               $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 63) == 0);
         if ($urandom_range(0, 199) == 0) async_reset();
         else step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
